// File: rtl/nios_system_keys_pkg.sv
// Shared constants and helpers for the pushbutton conditioning block.
// Default timing targets 1 ms ticks on a 50 MHz clock.
package nios_system_keys_pkg;

  localparam int DEFAULT_TICK_DIV     = 50000;
  localparam int DEFAULT_STABLE_TICKS = 10;

  // Level a key shows when it is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/nios_system_key_debounce_chan.sv
// One debounced key channel: accepts a level change only after it has
// persisted, unbroken, across STABLE_TICKS prescaler ticks.
module nios_system_key_debounce_chan
  import nios_system_keys_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync,
  output logic level,
  output logic press_evt,
  output logic release_evt
);

  localparam logic REL = released_level(ACTIVE_LOW);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CLAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] cnt;

  // Qualify differing levels tick by tick; any return to stable restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      level       <= REL;
      cnt         <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CLAST) begin
          level <= sync;
          cnt   <= '0;
          if (sync == REL) release_evt <= 1'b1;
          else             press_evt   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nios_system_key_debouncer.sv
// Pushbutton conditioner for the push-keys PIO: synchroniser, shared
// tick prescaler and one debounce channel per key.
module nios_system_key_debouncer
  import nios_system_keys_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_in,
  output logic [NUM_KEYS-1:0] keys_out,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam logic REL = released_level(ACTIVE_LOW);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;
  logic [PW-1:0]       pcnt;
  logic                tick;

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= {NUM_KEYS{REL}};
      s2 <= {NUM_KEYS{REL}};
    end else begin
      s1 <= keys_in;
      s2 <= s1;
    end
  end

  // Free-running prescaler producing the shared debounce tick.
  always_ff @(posedge clk) begin
    if (reset)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  assign tick = (pcnt == PLAST);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    nios_system_key_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .sync        (s2[i]),
      .level       (keys_out[i]),
      .press_evt   (key_press[i]),
      .release_evt (key_release[i])
    );
  end

endmodule
